button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
// - Upstream front end for the memory game's two push buttons (Move, Select).
// - Takes the raw active-low pad signals and produces clean, debounced, active-high
//   levels plus single-cycle press pulses.
// - The pulses feed the cursor control (controlesJuego), the board memory and the
//   game FSM, replacing the raw ~btnMove/~btnSelect taps.
// - Runs in the 25 MHz vga_clk domain.
// PARAMETERS
// - DB_CYCLES      250000    consecutive stable cycles needed to accept a level change (10 ms @25 MHz)
// - REPEAT_DELAY   12500000  cycles Move is held before the first auto-repeat pulse (only with macro)
// - REPEAT_PERIOD  5000000   cycles between later auto-repeat pulses (only with macro)
// PORTS
// - vga_clk       input   1   block clock, 25 MHz
// - rst           input   1   asynchronous, active-low reset
// - btnMove       input   1   raw Move button, active-low, asynchronous to vga_clk
// - btnSelect     input   1   raw Select button, active-low, asynchronous to vga_clk
// - move_level    output  1   debounced Move, 1 = pressed
// - select_level  output  1   debounced Select, 1 = pressed
// - move_pulse    output  1   one-cycle strobe per accepted Move press (and per repeat)
// - select_pulse  output  1   one-cycle strobe per accepted Select press
// BEHAVIOUR
// - Interface: one clock, vga_clk. Reset rst is asynchronous and active-low.
// - Reset (rst=0): all outputs 0; synchronizer flops preset to 1 (released); counters 0;
//   both FSMs in IDLE. Reset may assert at any cycle and aborts any debounce or repeat.
// - Synchronizer: each button passes through 2 flops. The sync output lags the pad by 2 cycles.
// - Per-button FSM:
//   - IDLE: sync=0 -> PRESS_WAIT with cnt=1.
//   - PRESS_WAIT: sync=0 -> cnt++. sync=1 -> IDLE, cnt=0.
//     cnt==DB_CYCLES-1 with sync=0 -> HELD; level<=1 and pulse<=1 for exactly 1 cycle.
//   - HELD: sync=1 -> RELEASE_WAIT with cnt=1.
//   - RELEASE_WAIT: sync=1 -> cnt++. sync=0 -> HELD, cnt=0, no new pulse.
//     cnt==DB_CYCLES-1 with sync=1 -> IDLE; level<=0.
// - Latency: pulse and level rise DB_CYCLES+2 cycles after the pad is first sampled low,
//   given the pad stays low throughout. Release latency is the same.
// - Glitches shorter than DB_CYCLES cycles never change level and never pulse.
// - Counter: $clog2(DB_CYCLES)+1 bits wide. It saturates and never wraps.
// - Simultaneous events: buttons are independent, so both pulses may assert in the same
//   cycle. Consumers treat Select as having priority.
// - Button held across reset release: it is seen as a new press. After DB_CYCLES+2
//   cycles, one pulse fires.
// - Registered outputs: no combinational path from pads to outputs.
// CONFIGURATION
// - BTN_AUTOREPEAT_EN defined:
//   - Move only. While in HELD, a repeat counter runs.
//   - First extra move_pulse fires REPEAT_DELAY cycles after the press pulse, then one
//     every REPEAT_PERIOD cycles.
//   - Leaving HELD clears the repeat counter.
//   - Select never repeats.
// - BTN_AUTOREPEAT_EN undefined:
//   - Exactly one move_pulse per accepted press.
//   - No repeat counter is synthesized. REPEAT_* parameters are ignored.
// TESTING
// (bench uses DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
// - Reset: rst=0 with buttons toggling -> all outputs 0. After rst=1 with pads high ->
//   outputs stay 0 for 50 cycles.
// - Clean press: btnMove low from cycle 10 -> move_pulse high only at cycle 16,
//   move_level 1 from cycle 16. Release at cycle 40 -> level falls at cycle 46, no pulse.
// - Bounce: btnSelect low 3 cycles, high 1, low 3, high -> no select_pulse, select_level stays 0.
//   Then a 10-cycle low -> exactly one pulse.
// - Simultaneous: both pads low at the same cycle -> move_pulse and select_pulse high in the
//   same cycle, each exactly once.
// - Mid-operation reset: rst=0 during Select PRESS_WAIT -> no pulse. After rst=1 with the
//   pad still low -> one pulse DB_CYCLES+2 cycles after the first sampled low.
// - Auto-repeat (macro on): hold Move for 60 cycles -> pulses at t, t+20, t+28, t+36, t+44,
//   t+52. Macro off -> a single pulse at t.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced level and press-pulse front end for the Move/Select buttons
//
// Purpose:
//   Conditions the two raw active-low pad buttons of the memory game (Move, Select)
//   into clean active-high levels and single-cycle press pulses in the vga_clk domain.
//   Each button: 2-flop synchronizer -> debounce FSM -> registered level/pulse.
//
// Optional feature (macro BTN_AUTOREPEAT_EN):
//   When defined, Move auto-repeats while held: first extra pulse REPEAT_DELAY cycles
//   after the press pulse, then one every REPEAT_PERIOD cycles. Select never repeats.
//   When undefined, no repeat counter exists and the REPEAT_* parameters are ignored.
//
// Ports:
//   vga_clk      in   block clock (25 MHz)
//   rst          in   asynchronous active-low reset
//   btnMove      in   raw Move button, active-low, asynchronous
//   btnSelect    in   raw Select button, active-low, asynchronous
//   move_level   out  debounced Move, 1 = pressed
//   select_level out  debounced Select, 1 = pressed
//   move_pulse   out  one-cycle strobe per accepted Move press (and per repeat)
//   select_pulse out  one-cycle strobe per accepted Select press

module button_conditioner #(
    parameter int DB_CYCLES     = 250000,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic vga_clk,
    input  logic rst,
    input  logic btnMove,
    input  logic btnSelect,
    output logic move_level,
    output logic select_level,
    output logic move_pulse,
    output logic select_pulse
);

`ifdef BTN_AUTOREPEAT_EN
    localparam bit MOVE_REPEAT = 1'b1;
`else
    localparam bit MOVE_REPEAT = 1'b0;
`endif

    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0] pad_n;
    logic [1:0] level_vec;
    logic [1:0] pulse_vec;

    // Index 0 = Move, index 1 = Select.
    assign pad_n = {btnSelect, btnMove};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        state_t          state_q, state_d;
        logic [1:0]      sync_q, sync_d;
        logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
        logic            level_q, level_d;
        logic            pulse_q, pulse_d;
        logic            released;
        logic            rpt_fire;

        always_comb begin
            sync_d = {sync_q[0], pad_n[b]};
        end

        // Synchronized pad, 1 = button released.
        assign released = sync_q[1];
        assign cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

        // State register; outputs are registered here too so no pad-to-output path exists.
        always_ff @(posedge vga_clk or negedge rst) begin
            if (!rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                sync_q  <= 2'b11;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                sync_q  <= sync_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        // Next-state logic: cnt counts consecutive samples at the candidate new level.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_IDLE: begin
                    if (!released) begin
                        state_d = S_PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_PRESS_WAIT: begin
                    if (released) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_HELD: begin
                    if (released) begin
                        state_d = S_RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (!released) begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Output logic: a bounce back from RELEASE_WAIT to HELD keeps level high,
        // so the rising-edge pulse cannot fire twice for one press.
        always_comb begin
            level_d = (state_q == S_HELD) || (state_q == S_RELEASE_WAIT);
            pulse_d = (level_d && !level_q) || rpt_fire;
        end

        // The reload arithmetic below needs REPEAT_DELAY >= REPEAT_PERIOD > 0.
        if ((b == 0) && MOVE_REPEAT && (REPEAT_PERIOD > 0) && (REPEAT_DELAY >= REPEAT_PERIOD)) begin : g_repeat
            localparam int RW = $clog2(REPEAT_DELAY + 1);
            localparam logic [RW-1:0] RPT_FIRE_AT = RW'(REPEAT_DELAY);
            localparam logic [RW-1:0] RPT_RELOAD  = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

            logic [RW-1:0] rpt_q, rpt_d;
            logic          fire;

            // rpt_q equals the number of cycles since the press pulse, so firing at
            // REPEAT_DELAY lands exactly REPEAT_DELAY after it; the reload value
            // makes every later hit REPEAT_PERIOD cycles apart.
            always_comb begin
                rpt_d = '0;
                fire  = 1'b0;
                if (state_q == S_HELD) begin
                    if (rpt_q == RPT_FIRE_AT) begin
                        fire  = 1'b1;
                        rpt_d = RPT_RELOAD;
                    end else begin
                        rpt_d = rpt_q + RW'(1);
                    end
                end
            end

            always_ff @(posedge vga_clk or negedge rst) begin
                if (!rst) begin
                    rpt_q <= '0;
                end else begin
                    rpt_q <= rpt_d;
                end
            end

            assign rpt_fire = fire;
        end else begin : g_no_repeat
            assign rpt_fire = 1'b0;
        end

        assign level_vec[b] = level_q;
        assign pulse_vec[b] = pulse_q;
    end

    assign move_level   = level_vec[0];
    assign select_level = level_vec[1];
    assign move_pulse   = pulse_vec[0];
    assign select_pulse = pulse_vec[1];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner

module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic vga_clk;
    logic rst;
    logic btnMove;
    logic btnSelect;
    logic move_level;
    logic select_level;
    logic move_pulse;
    logic select_pulse;

    int n_total = 0;
    int n_pass  = 0;

    button_conditioner #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .btnMove     (btnMove),
        .btnSelect   (btnSelect),
        .move_level  (move_level),
        .select_level(select_level),
        .move_pulse  (move_pulse),
        .select_pulse(select_pulse)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Reference model: a level is accepted after DB consecutive samples that differ
    // from the accepted level; the synchronizer is a two-sample delay line.
    int  m_run [2];
    bit  m_acc [2];
    bit  m_lvl [2];
    bit  m_pls [2];
    bit  m_s   [2];
    int  m_hc;
    bit  m_hb;
    bit  m_fire;
    bit  mq_m[$];
    bit  mq_s[$];

    always @(posedge vga_clk) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                m_run[b] = 0;
                m_acc[b] = 1'b0;
                m_lvl[b] = 1'b0;
                m_pls[b] = 1'b0;
            end
            m_hc = 0;
            mq_m.delete();
            mq_s.delete();
            mq_m.push_back(1'b1);
            mq_m.push_back(1'b1);
            mq_s.push_back(1'b1);
            mq_s.push_back(1'b1);
        end else begin
            m_s[0] = mq_m.pop_front();
            m_s[1] = mq_s.pop_front();
            mq_m.push_back(btnMove);
            mq_s.push_back(btnSelect);
            for (int b = 0; b < 2; b++) begin
                m_hb   = m_acc[b] && (m_run[b] == 0);
                m_fire = 1'b0;
                if (b == 0 && REP) begin
                    if (m_hb) begin
                        m_hc++;
                        m_fire = (m_hc > RD) && (((m_hc - 1 - RD) % RP) == 0);
                    end else begin
                        m_hc = 0;
                    end
                end
                m_pls[b] = (m_acc[b] && !m_lvl[b]) || m_fire;
                m_lvl[b] = m_acc[b];
                if ((!m_s[b]) != m_acc[b]) m_run[b]++;
                else m_run[b] = 0;
                if (m_run[b] == DB) begin
                    m_acc[b] = !m_acc[b];
                    m_run[b] = 0;
                end
            end
        end
    end

    typedef struct {
        int         rep;
        bit         mv_n;
        bit         sel_n;
        logic [3:0] exp;   // {move_level, move_pulse, select_level, select_pulse}
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input int rep, input bit m, input bit s, input logic [3:0] e);
        vec_t v;
        v.rep   = rep;
        v.mv_n  = m;
        v.sel_n = s;
        v.exp   = e;
        tbl.push_back(v);
    endtask

    task automatic cyc(input bit m, input bit s);
        btnMove   = m;
        btnSelect = s;
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] exp);
        logic [3:0] got;
        got = {move_level, move_pulse, select_level, select_pulse};
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s idx=%0d got=%b expected=%b (ml,mp,sl,sp)", name, idx, got, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          rm;
        int          rs;
        bit          vm;
        bit          vs;
        logic [3:0]  e;

        // Table: clean Move press, Select bounce then clean press, simultaneous press.
        add_vec(10, 1, 1, 4'b0000);
        add_vec(6,  0, 1, 4'b0000);
        add_vec(1,  0, 1, 4'b1100);
        add_vec(19, 0, 1, 4'b1000);
        add_vec(1,  0, 1, {1'b1, REP, 2'b00});
        add_vec(3,  0, 1, 4'b1000);
        add_vec(6,  1, 1, 4'b1000);
        add_vec(4,  1, 1, 4'b0000);
        add_vec(3,  1, 0, 4'b0000);
        add_vec(1,  1, 1, 4'b0000);
        add_vec(3,  1, 0, 4'b0000);
        add_vec(8,  1, 1, 4'b0000);
        add_vec(6,  1, 0, 4'b0000);
        add_vec(1,  1, 0, 4'b0011);
        add_vec(3,  1, 0, 4'b0010);
        add_vec(6,  1, 1, 4'b0010);
        add_vec(4,  1, 1, 4'b0000);
        add_vec(6,  0, 0, 4'b0000);
        add_vec(1,  0, 0, 4'b1111);
        add_vec(3,  0, 0, 4'b1010);
        add_vec(6,  1, 1, 4'b1010);
        add_vec(4,  1, 1, 4'b0000);

        rst       = 1'b0;
        btnMove   = 1'b1;
        btnSelect = 1'b1;
        @(negedge vga_clk);

        // Reset held while pads toggle.
        for (int i = 0; i < 10; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("reset_hold", i, 4'b0000);
        end
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, 1'b1);
            check("post_reset_idle", i, 4'b0000);
        end

        idx = 0;
        foreach (tbl[k]) begin
            for (int r = 0; r < tbl[k].rep; r++) begin
                cyc(tbl[k].mv_n, tbl[k].sel_n);
                check("table", idx, tbl[k].exp);
                idx++;
            end
        end

        // Reset during Select PRESS_WAIT, pad kept low through reset release.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            check("midrst_pw", i, 4'b0000);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            check("midrst_in", i, 4'b0000);
        end
        rst = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cyc(1'b1, 1'b0);
            check("midrst_after", j, {2'b00, 1'(j >= 6), 1'(j == 6)});
        end
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, 1'b1);
            check("midrst_release", j, {2'b00, 1'(j < 6), 1'b0});
        end

        // Move held 60 cycles: auto-repeat pulses when enabled, single pulse otherwise.
        for (int i = 0; i < 72; i++) begin
            cyc(i >= 60, 1'b1);
            e = {1'(i >= 6 && i < 66),
                 1'((i == 6) || (REP && i >= 26 && i <= 58 && ((i - 26) % 8) == 0)),
                 2'b00};
            check("autorepeat", i, e);
        end

        // Randomized run-length stimulus against the reference model.
        rm = 0;
        rs = 0;
        vm = 1'b1;
        vs = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (rm == 0) begin
                vm = 1'($urandom_range(0, 1));
                rm = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 7);
            end
            if (rs == 0) begin
                vs = 1'($urandom_range(0, 1));
                rs = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 7);
            end
            rm--;
            rs--;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst = 1'b0;
            cyc(vm, vs);
            if (!rst) check("rand_reset", i, 4'b0000);
            else check("rand_model", i, {m_lvl[0], m_pls[0], m_lvl[1], m_pls[1]});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
